fir_out_fifo: RTL and testbench

Output buffer stage that sits directly downstream of the FIR filter. It captures 8-bit filtered samples, optionally decimates them by a programmable factor, and holds them in a small first-word-fall-through FIFO. Samples leave on an AXI-stream-style valid/ready master port towards the output pins or a serializer. A sticky overflow flag records any sample the FIR presented while the buffer could not accept it.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_out_fifo_if.sv | 22 ++
 rtl/fir_fifo_mem.sv | 26 ++
 rtl/fir_out_fifo.sv | 125 ++++++++++++
 tb/tb_fir_out_fifo.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Constants shared between the FIR datapath and its output buffer.
package fir_pkg;

    localparam int unsigned FIR_DATA_W      = 8;
    localparam int unsigned DEFAULT_DEPTH   = 8;
    localparam int unsigned DEFAULT_DECIM_W = 4;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fir_out_fifo_if.sv
// Valid/ready sample stream used on both sides of the FIR output buffer.
interface fir_out_fifo_if #(
    parameter int unsigned DATA_W = fir_pkg::FIR_DATA_W
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/fir_fifo_mem.sv
// Register-array storage: one synchronous write port, asynchronous read port.
module fir_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; validity is tracked by the level.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_fifo.sv
// FIR output buffer: optional decimation, FWFT FIFO, sticky overflow flag.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W  = FIR_DATA_W,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned DECIM_W = DEFAULT_DECIM_W
) (
    input  logic                            clk,
    input  logic                            reset,
    fir_out_fifo_if.slave                   s_axis,
    fir_out_fifo_if.master                  m_axis,
    input  logic [DECIM_W-1:0]              decim,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic                            overflow,
    input  logic                            clr_ovf
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = level_width(DEPTH);

    // Pointer wrap relies on a power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fir_out_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LEVEL_W-1:0] level_q;
    logic [DECIM_W-1:0] dcnt;
    logic               ovf_q;

    logic               full;
    logic               empty;
    logic               accept;
    logic               wr_en;
    logic               rd_en;
    logic               blocked;
    logic [DATA_W-1:0]  head;

    // Handshake qualifiers, all derived from registered occupancy.
    always_comb begin
        full    = (level_q == LEVEL_W'(DEPTH));
        empty   = (level_q == '0);
        accept  = s_axis.tvalid && !full;
        wr_en   = accept && (dcnt == '0);
        rd_en   = !empty && m_axis.tready;
        blocked = s_axis.tvalid && full;
    end

    fir_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (s_axis.tdata),
        .raddr  (rd_ptr),
        .rdata  (head)
    );

    // Write pointer advances only for samples that survive decimation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // Read pointer advances on each completed output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: simultaneous write and read leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Decimation counter: reload from decim on a kept sample, count down on drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
        end else if (accept) begin
            if (dcnt == '0) begin
                dcnt <= decim;
            end else begin
                dcnt <= dcnt - DECIM_W'(1);
            end
        end
    end

    // Sticky overflow; a new loss in the clearing cycle keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (blocked) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign s_axis.tready = !full;
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = empty ? '0 : head;
    assign level         = level_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Self-checking bench for fir_out_fifo: vector table plus queue scoreboard.
module tb_fir_out_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic       clk;
    logic       reset;
    logic [3:0] decim;
    logic [3:0] level;
    logic       overflow;
    logic       clr_ovf;

    fir_out_fifo_if #(.DATA_W(DW)) s_if ();
    fir_out_fifo_if #(.DATA_W(DW)) m_if ();

    fir_out_fifo #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .DECIM_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .decim    (decim),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0] sb_q [$];
    int         mdcnt = 0;
    bit         movf  = 1'b0;
    int         n_writes = 0;
    int         n_reads  = 0;
    int         n_hs     = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already set: check, model one edge, advance.
    task automatic cycle();
        bit mvalid;
        bit mready;
        mvalid = (sb_q.size() != 0);
        mready = (sb_q.size() < DEPTH);
        chk("level", int'(level), sb_q.size());
        chk("m_tvalid", int'(m_if.tvalid), int'(mvalid));
        chk("s_tready", int'(s_if.tready), int'(mready));
        chk("overflow", int'(overflow), int'(movf));
        if (!mvalid) chk("m_tdata_empty", int'(m_if.tdata), 0);
        if (mvalid && m_if.tready) begin
            chk("out_data", int'(m_if.tdata), int'(sb_q.pop_front()));
            n_reads++;
        end
        if (s_if.tvalid && mready) begin
            n_hs++;
            if (mdcnt == 0) begin
                sb_q.push_back(s_if.tdata);
                mdcnt = int'(decim);
                n_writes++;
            end else begin
                mdcnt--;
            end
        end
        if (s_if.tvalid && !mready) movf = 1'b1;
        else if (clr_ovf)           movf = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         rdy;
        int         lvl;
        bit         mv;
        logic [7:0] td;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int rd0;
        int wr0;
        int hs0;
        logic [7:0] dnext;

        // Push three, drain, empty read, push-while-empty, level-1 simultaneous.
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h22};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h33};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 8'h44, 1'b1, 1, 1'b1, 8'h44};
        vecs[8] = '{1'b1, 8'h55, 1'b1, 1, 1'b1, 8'h55};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

        reset       = 1'b1;
        decim       = 4'd0;
        clr_ovf     = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        m_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state, idle with m_tready high.
        chk("rst_level", int'(level), 0);
        chk("rst_m_tvalid", int'(m_if.tvalid), 0);
        chk("rst_s_tready", int'(s_if.tready), 1);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_m_tdata", int'(m_if.tdata), 0);
        repeat (2) cycle();

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            s_if.tvalid = vecs[i].v;
            s_if.tdata  = vecs[i].d;
            m_if.tready = vecs[i].rdy;
            cycle();
            chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
            chk($sformatf("vec%0d_mvalid", i), int'(m_if.tvalid), int'(vecs[i].mv));
            chk($sformatf("vec%0d_mdata", i), int'(m_if.tdata), int'(vecs[i].td));
        end

        // Decimate by 3: only 0x01, 0x04, 0x07 survive.
        decim = 4'd2;
        m_if.tready = 1'b1;
        rd0 = n_reads;
        hs0 = n_hs;
        for (int i = 1; i <= 9; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'(i);
            cycle();
        end
        s_if.tvalid = 1'b0;
        decim = 4'd0;
        repeat (3) cycle();
        chk("decim_handshakes", n_hs - hs0, 9);
        chk("decim_outputs", n_reads - rd0, 3);
        chk("decim_overflow", int'(overflow), 0);

        // Overflow: ninth sample into a full FIFO is lost.
        m_if.tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'hA0 + 8'(i);
            cycle();
        end
        s_if.tvalid = 1'b0;
        chk("ovf_s_tready", int'(s_if.tready), 0);
        chk("ovf_level", int'(level), 8);
        chk("ovf_flag", int'(overflow), 1);
        m_if.tready = 1'b1;
        rd0 = n_reads;
        repeat (10) cycle();
        chk("ovf_drained", n_reads - rd0, 8);
        chk("ovf_still_set", int'(overflow), 1);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);

        // Full FIFO with both sides held active; clear collides with a new loss.
        m_if.tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'hB0 + 8'(i);
            cycle();
        end
        m_if.tready = 1'b1;
        clr_ovf     = 1'b1;
        dnext       = 8'hC0;
        wr0         = n_writes;
        for (int i = 0; i < 24; i++) begin
            bit will_acc;
            will_acc   = (sb_q.size() < DEPTH);
            s_if.tdata = dnext;
            cycle();
            if (will_acc) dnext = dnext + 8'd1;
            if (i == 0) begin
                clr_ovf = 1'b0;
                chk("set_wins_ovf", int'(overflow), 1);
                chk("full_first_level", int'(level), 7);
            end
        end
        chk("full_throughput", n_writes - wr0, 23);
        s_if.tvalid = 1'b0;
        repeat (10) cycle();
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;

        // Reset asserted mid-stream with five entries held.
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'hD0 + 8'(i);
            cycle();
        end
        s_if.tvalid = 1'b0;
        chk("pre_rst_level", int'(level), 5);
        reset = 1'b1;
        #1;
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_mvalid", int'(m_if.tvalid), 0);
        chk("async_rst_mdata", int'(m_if.tdata), 0);
        sb_q.delete();
        mdcnt = 0;
        movf  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h5A;
        cycle();
        s_if.tvalid = 1'b0;
        chk("post_rst_head", int'(m_if.tdata), 8'h5A);
        m_if.tready = 1'b1;
        repeat (3) cycle();

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
